// File: rtl/ysyx_23060332_wbu.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060332_wbu
// Purpose  : Writeback unit. Arbitrates between EXU results and LSU load
//            responses (round-robin on ties), formats load data, registers a
//            single regfile write per cycle and keeps a pending-load
//            scoreboard that the IDU uses to stall on read-after-load hazards.
// Ports    : clk, rst             - clock, synchronous active-high reset
//            exu_valid/ready/rd/wen/data - EXU result channel
//            lsu_valid/ready/rd/funct3/addr_lo/rdata - load response channel
//            ld_issue, ld_issue_rd - load issue notification (sets busy)
//            raddr1, raddr2, stall - IDU hazard query
//            waddr, wdata, reg_wen - regfile write port (registered)
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060332_wbu #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  // EXU channel
  input  logic            exu_valid,
  output logic            exu_ready,
  input  logic [AW-1:0]   exu_rd,
  input  logic            exu_wen,
  input  logic [XLEN-1:0] exu_data,
  // LSU channel
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [2:0]      lsu_funct3,
  input  logic [1:0]      lsu_addr_lo,
  input  logic [XLEN-1:0] lsu_rdata,
  // scoreboard
  input  logic            ld_issue,
  input  logic [AW-1:0]   ld_issue_rd,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic            stall,
  // regfile write port
  output logic [AW-1:0]   waddr,
  output logic [XLEN-1:0] wdata,
  output logic            reg_wen
);

  localparam logic C_GRANT_EXU = 1'b0;
  localparam logic C_GRANT_LSU = 1'b1;

  logic            r_last_grant;
  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_next;
  logic            w_grant_lsu;
  logic            w_exu_fire;
  logic            w_lsu_fire;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_load_data;

  // ---------------- arbitration ----------------
  // LSU wins when it is the only requester, or on a tie when the EXU had
  // the previous grant. Last_grant resets to EXU so the first tie goes LSU.
  assign w_grant_lsu = lsu_valid && (!exu_valid || (r_last_grant == C_GRANT_EXU));
  assign lsu_ready   = w_grant_lsu;
  assign exu_ready   = exu_valid && !w_grant_lsu;
  assign w_exu_fire  = exu_valid && exu_ready;
  assign w_lsu_fire  = lsu_valid && lsu_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= C_GRANT_EXU;
    end else if (w_lsu_fire) begin
      r_last_grant <= C_GRANT_LSU;
    end else if (w_exu_fire) begin
      r_last_grant <= C_GRANT_EXU;
    end
  end

  // ---------------- load formatting ----------------
  // Halves are selected by addr_lo[1] only; addr_lo[0] is ignored.
  assign w_byte = lsu_rdata[{lsu_addr_lo, 3'b000} +: 8];
  assign w_half = lsu_rdata[{lsu_addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    w_load_data = lsu_rdata;
    case (lsu_funct3)
      3'b000:  w_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{(XLEN-16){w_half[15]}}, w_half};
      3'b100:  w_load_data = {{(XLEN-8){1'b0}}, w_byte};
      3'b101:  w_load_data = {{(XLEN-16){1'b0}}, w_half};
      default: w_load_data = lsu_rdata;
    endcase
  end

  // ---------------- output register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      waddr   <= '0;
      wdata   <= '0;
      reg_wen <= 1'b0;
    end else if (w_exu_fire) begin
      waddr   <= exu_rd;
      wdata   <= exu_data;
      reg_wen <= exu_wen && (exu_rd != '0);
    end else if (w_lsu_fire) begin
      waddr   <= lsu_rd;
      wdata   <= w_load_data;
      reg_wen <= (lsu_rd != '0);
    end else begin
      reg_wen <= 1'b0;
    end
  end

  // ---------------- pending-load scoreboard ----------------
  // Set is applied after clear: a load issued on the same edge that an older
  // load to the same rd completes is still outstanding.
  always_comb begin
    w_busy_next = r_busy;
    if (w_lsu_fire) begin
      w_busy_next[lsu_rd] = 1'b0;
    end
    if (ld_issue && (ld_issue_rd != '0)) begin
      w_busy_next[ld_issue_rd] = 1'b1;
    end
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  assign stall = ((raddr1 != '0) && r_busy[raddr1]) ||
                 ((raddr2 != '0) && r_busy[raddr2]);

endmodule
`default_nettype wire
